// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// FSM states, access sizes, latched request bundle.
package lsu_pkg;

  localparam int LSU_MEM_WORDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef struct packed {
    logic        write;
    logic        uns;
    lsu_size_e   size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Half needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic lsu_misaligned(
    input lsu_size_e  sz,
    input logic [1:0] lo
  );
    return ((sz == SZ_HALF) && lo[0]) ||
           ((sz == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and word memory port.
// slave = LSU side, master = CPU/memory side.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;

  modport slave (
    input  req_valid, req_write, req_unsigned,
    input  req_size, req_addr, req_wdata,
    input  mem_readData,
    output req_ready,
    output resp_valid, resp_error, resp_rdata,
    output mem_address, mem_read, mem_write,
    output mem_writeData
  );

  modport master (
    output req_valid, req_write, req_unsigned,
    output req_size, req_addr, req_wdata,
    output mem_readData,
    input  req_ready,
    input  resp_valid, resp_error, resp_rdata,
    input  mem_address, mem_read, mem_write,
    input  mem_writeData
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads
// and lane merge for partial stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  lsu_size_e   size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  bit_off;

  // Select lane, extend it, and build merged word.
  always_comb begin
    bit_off   = {lane, 3'b000};
    byte_sel  = rd_word[bit_off +: 8];
    half_sel  = lane[1] ? rd_word[31:16]
                        : rd_word[15:0];
    load_data = rd_word;
    merged    = rd_word;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        load_data = {{24{byte_sel[7] & ~uns}},
                     byte_sel};
        merged[bit_off +: 8] = wdata[7:0];
      end
      (size == SZ_HALF): begin
        load_data = {{16{half_sel[15] & ~uns}},
                     half_sel};
        if (lane[1]) begin
          merged[31:16] = wdata;
        end else begin
          merged[15:0] = wdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit.
// Faults short-circuit to RESP without memory traffic.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        fault_q, fault_d;
  logic [31:0] rd_word_q, rd_word_d;

  logic        in_fault;
  lsu_size_e   in_size;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [31:0] word_addr;

  assign in_size   = lsu_size_e'(bus.req_size);
  assign word_addr = {2'b00, req_q.addr[31:2]};

  // Classify the incoming request as faulting.
  always_comb begin
    in_fault = (in_size == SZ_ILL) ||
               lsu_misaligned(in_size,
                              bus.req_addr[1:0]) ||
               ({2'b00, bus.req_addr[31:2]} >=
                32'(MEM_WORDS));
  end

  lsu_lane_align u_align (
    .rd_word   (rd_word_q),
    .size      (req_q.size),
    .lane      (req_q.addr[1:0]),
    .uns       (req_q.uns),
    .wdata     (req_q.wdata[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  // Next-state and request latching.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    fault_d   = fault_q;
    rd_word_d = rd_word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.write = bus.req_write;
          req_d.uns   = bus.req_unsigned;
          req_d.size  = in_size;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          fault_d     = in_fault;
          rd_word_d   = '0;
          if (in_fault) begin
            state_d = ST_RESP;
          end else if (bus.req_write &&
                       in_size == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        rd_word_d = bus.mem_readData;
        state_d   = req_q.write ? ST_WRITE
                                : ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      fault_q   <= 1'b0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      fault_q   <= fault_d;
      rd_word_q <= rd_word_d;
    end
  end

  // Outputs; strobes are masked during reset so an
  // aborted access never writes.
  always_comb begin
    bus.req_ready     = (state_q == ST_IDLE);
    bus.resp_valid    = 1'b0;
    bus.resp_error    = 1'b0;
    bus.resp_rdata    = '0;
    bus.mem_address   = '0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_writeData = '0;
    if (!reset) begin
      unique case (state_q)
        ST_READ: begin
          bus.mem_read    = 1'b1;
          bus.mem_address = word_addr;
        end
        ST_WRITE: begin
          bus.mem_write     = 1'b1;
          bus.mem_address   = word_addr;
          bus.mem_writeData =
            (req_q.size == SZ_WORD) ? req_q.wdata
                                    : merged;
        end
        ST_RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_error = fault_q;
          if (!fault_q && !req_q.write) begin
            bus.resp_rdata = load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words in the downstream data memory.
REQ-002 SHALL have port clock  in  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid/req_ready  in/out  1/1  request handshake from the CPU; accepted when both are high on a posedge.
REQ-005 SHALL have ports req_write, req_unsigned  in  1 each  store vs load; zero-extend vs sign-extend a load.
REQ-006 SHALL have port req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have ports req_addr, req_wdata  in  32 each  byte address; store data in the low bytes.
REQ-008 SHALL have ports resp_valid, resp_error, resp_rdata  out  1/1/32  completion pulse, fault flag, load result.
REQ-009 SHALL have ports mem_address, mem_read, mem_write, mem_writeData  out  32/1/1/32  word-indexed memory port.
REQ-010 SHALL have port mem_readData  in  32  memory read word, valid the cycle after mem_read is high.

Function
REQ-011 SHALL implement the states IDLE, READ, CAPTURE, WRITE, RESP; req_ready is high only in IDLE.
REQ-012 On acceptance, SHALL latch all req_* fields; it SHALL ignore req_* fields outside IDLE.
REQ-013 SHALL treat a request as faulting when req_size=11, a half access has addr[0]=1, a word access has addr[1:0]!=0, or addr[31:2]>=MEM_WORDS.
REQ-014 Faulting request: IDLE->RESP, no mem_read/mem_write ever asserted, resp_error=1, resp_rdata=0.
REQ-015 Word store: IDLE->WRITE->RESP; in WRITE, mem_write=1 and mem_writeData=req_wdata.
REQ-016 Load or byte/half store: IDLE->READ->CAPTURE; in READ, mem_read=1.
REQ-017 In CAPTURE, SHALL register mem_readData; a load then goes to RESP, and a partial store goes to WRITE with the merged word.
REQ-018 Lane mapping SHALL be little-endian: byte k=bits[8k+7:8k] for k=addr[1:0]; half = bits[15:0] if addr[1]=0, else bits[31:16].
REQ-019 A load result SHALL be the selected lane, sign-extended if req_unsigned=0 and zero-extended otherwise; a word load passes through unchanged.
REQ-020 A partial-store merge SHALL replace only the selected lane with req_wdata[7:0] or [15:0] and keep the other bytes as read.
REQ-021 mem_address SHALL equal {2'b0, addr[31:2]} whenever mem_read or mem_write is high, and 0 otherwise; mem_writeData SHALL be 0 when mem_write is low.
REQ-022 mem_read and mem_write SHALL never be high in the same cycle.
REQ-023 In RESP, resp_valid SHALL be high for exactly one cycle, then the FSM returns to IDLE; resp_rdata=0 for stores.
REQ-024 Latency from the acceptance edge to resp_valid SHALL be: fault 1 cycle, word store 2, load 3, partial store 4.
REQ-025 A new request SHALL be accepted no earlier than the cycle after RESP, so there is no back-to-back overlap.

Reset
REQ-026 Reset SHALL force IDLE and set req_ready=1, with resp_valid, resp_error, resp_rdata, mem_read, mem_write, mem_address and mem_writeData all 0.
REQ-027 Reset asserted mid-operation SHALL abort the access, and no mem_write SHALL occur in the reset cycle or any later cycle for the aborted request.
REQ-028 Reset SHALL take priority over a simultaneous req_valid; that request is not accepted.

Structure
REQ-029 The state encoding, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the MEM_WORDS default SHALL live in a shared package, lsu_pkg.
REQ-030 Lane extract/extend and merge SHALL be one combinational sub-module, lsu_lane_align, instantiated once.

Verification
REQ-031 Memory word 1=0x8899AABB; signed byte load at addr 0x05 -> resp_rdata=0xFFFFFFAA, resp_valid 3 cycles after acceptance.
REQ-032 Same word; unsigned half load at addr 0x06 -> 0x00008899; signed half load -> 0xFFFF8899.
REQ-033 Half store of 0x1234 at addr 0x04 -> one READ then one mem_write of 0x8899_1234 to word 1, with resp_valid 4 cycles after acceptance.
REQ-034 Word load at 0x02, half load at 0x03, size=11, and byte store at 0x100 -> resp_error=1 at 1 cycle each, with no memory strobes.
REQ-035 Reset asserted in the CAPTURE state of a byte store -> mem_write never asserted and memory unchanged; req_ready=1 the cycle after reset.
REQ-036 req_valid held high continuously for a word store then a load -> the second request is accepted only in the cycle after RESP, and the responses are correct in order.
